// File: rtl/mem_access_pkg.sv
// Shared types, funct3 encodings and request legality check for the load/store unit.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_W,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the size code is legal for the direction and the low address bits are aligned.
  // Range checking depends on the memory depth and is done by the caller.
  function automatic logic legal_access(input logic        is_store,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  addr_lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Lane select with sign/zero extension, plus the byte-lane mask of the same access
// so the store merge path uses exactly the lane the load path would read.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o,
  output logic [3:0]        mask_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byte_v = word_i[7:0];
    case (lane_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend by size; funct3[2] selects zero extension.
  always_comb begin
    data_o = word_i;
    mask_o = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        data_o = funct3_i[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        mask_o = 4'(4'b0001 << lane_i);
      end
      2'b01: begin
        data_o = funct3_i[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        mask_o = lane_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_o = word_i;
        mask_o = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word requests into word-aligned memory cycles,
// with read-modify-write for sub-word stores and up-front legality checking.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int unsigned        WIDX_W     = ADDR_W - 2;
  localparam logic [WIDX_W-1:0]  WORD_LIMIT = WIDX_W'(MEM_WORDS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                req_err;
  logic [DATA_W-1:0]   ext_data;
  logic [3:0]          lane_mask;
  logic [DATA_W-1:0]   lane_bits;
  logic [DATA_W-1:0]   store_rep;

  // Shared lane logic: extension for loads, byte mask for sub-word merges.
  load_extend u_load_extend (
    .word_i   (mem_RD),
    .lane_i   (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (ext_data),
    .mask_o   (lane_mask)
  );

  // Classify an incoming request: bad size code, misalignment or beyond memory depth.
  always_comb begin
    req_err = ~legal_access(we, funct3, addr[1:0]) |
              (addr[ADDR_W-1:2] >= WORD_LIMIT);
  end

  // Expand the lane mask to bits and replicate store data across all lanes of its size.
  always_comb begin
    lane_bits = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    store_rep = funct3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    err_d        = err_q;
    merge_d      = merge_q;
    rdata_d      = rdata_q;
    done         = 1'b0;
    err          = 1'b0;
    busy         = (state_q != ST_IDLE);
    mem_memwrite = 1'b0;
    mem_WD       = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = addr;
          wdata_d  = wdata;
          funct3_d = funct3;
          we_d     = we;
          err_d    = req_err;
          if (req_err) begin
            state_d = ST_DONE;
          end else if (!we) begin
            state_d = ST_LOAD;
          end else if (funct3 == F3_W) begin
            state_d = ST_STORE_W;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        if (!we_q) begin
          rdata_d = ext_data;
        end
        state_d = ST_DONE;
      end
      ST_STORE_W: begin
        mem_memwrite = 1'b1;
        mem_WD       = wdata_q;
        state_d      = ST_DONE;
      end
      ST_RMW_RD: begin
        merge_d = (mem_RD & ~lane_bits) | (store_rep & lane_bits);
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_memwrite = 1'b1;
        mem_WD       = merge_q;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_A = {addr_q[ADDR_W-1:2], 2'b00};
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_memwrite;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .mem_memwrite (mem_memwrite),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_RD       (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, word write on posedge.
  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  int          wr_cnt = 0;
  assign mem_RD = mem[mem_A[12:2]];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      ref_mem[i] = mem[i];
    end
    mem['h10]  = 32'h8899AABB;  ref_mem['h10]  = 32'h8899AABB;
    mem['h18]  = 32'h13579BDF;  ref_mem['h18]  = 32'h13579BDF;
    mem['h7FF] = 32'hCAFEF00D;  ref_mem['h7FF] = 32'hCAFEF00D;
    forever begin
      @(posedge clk);
      if (mem_memwrite) begin
        mem[mem_A[12:2]] <= mem_WD;
        wr_cnt++;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, got, want, $time);
    end
  endtask

  // Reference model state for the transaction in flight.
  bit          chk_en = 1'b0;
  bit          act    = 1'b0;
  int          s      = 0;
  int          lat_m  = 0;
  int          wc     = 0;
  bit          m_err  = 1'b0;
  bit          m_wcv  = 1'b0;
  logic [31:0] m_wd   = '0;
  logic [31:0] m_wa   = '0;
  logic [31:0] rd_old = '0;
  logic [31:0] rd_cur = '0;

  // Compute the outcome of one request from the access rules and update the reference memory.
  task automatic model_start(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
    int          off;
    logic [31:0] word, nw, v, mask;
    bit          illegal, mis, oor;
    off     = int'(a[1:0]);
    illegal = w ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis     = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    oor     = (a >> 2) >= 32'd2048;
    m_err   = illegal || mis || oor;
    word    = oor ? 32'h0 : ref_mem[a[12:2]];
    rd_old  = rd_cur;
    m_wcv   = 1'b0;
    m_wd    = '0;
    if (m_err) begin
      lat_m = 1;
    end else if (!w) begin
      lat_m = 2;
      v = word >> (8 * off);
      case (f3)
        3'd0:    v = {{24{v[7]}}, v[7:0]};
        3'd4:    v = {24'h0, v[7:0]};
        3'd1:    v = {{16{v[15]}}, v[15:0]};
        3'd5:    v = {16'h0, v[15:0]};
        default: v = word;
      endcase
      rd_cur = v;
    end else begin
      if (f3 == 3'd2) begin
        lat_m = 2;
        nw    = d;
      end else begin
        lat_m = 3;
        mask  = (f3 == 3'd0 ? 32'hFF : 32'hFFFF) << (8 * off);
        nw    = (word & ~mask) | ((d << (8 * off)) & mask);
      end
      ref_mem[a[12:2]] = nw;
      m_wd  = nw;
      m_wcv = 1'b1;
    end
    m_wa = {a[31:2], 2'b00};
    s    = cyc;
    wc   = s + lat_m - 1;
    act  = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  int          c;
  bit          e_busy, e_done, e_mw;
  logic [31:0] e_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
      end else begin
        c      = cyc;
        e_busy = act && (c > s) && (c <= s + lat_m);
        e_done = act && (c == s + lat_m);
        e_mw   = act && m_wcv && (c == wc);
        e_rd   = (act && c < s + lat_m) ? rd_old : rd_cur;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_done && m_err));
        chk("memwrite", 32'(mem_memwrite), 32'(e_mw));
        chk("rdata", rdata, e_rd);
        if (e_mw) chk("mem_WD", mem_WD, m_wd);
        if (e_busy) chk("mem_A", mem_A, m_wa);
      end
    end
  end

  // Issue one request; b2b=1 means req is raised during the previous DONE cycle.
  // Returns in the done cycle (posedge+1) with the measured latency.
  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input bit b2b, output int lat);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    if (b2b) begin
      @(posedge clk); #1;
    end
    model_start(w, f3, a, d);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) req = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL timeout: no done within 8 cycles for addr=%h", a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat;
  int w0;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Loads from 0x40 = 0x8899AABB
    run(1'b0, F3_B, 32'h41, 32'h0, 1'b0, lat);
    chk("lb41_lat", 32'(lat), 32'd2);
    chk("lb41_err", 32'(err), 32'd0);
    chk("lb41_rdata", rdata, 32'hFFFFFFAA);
    run(1'b0, F3_BU, 32'h41, 32'h0, 1'b0, lat);
    chk("lbu41_rdata", rdata, 32'h000000AA);
    run(1'b0, F3_H, 32'h42, 32'h0, 1'b0, lat);
    chk("lh42_rdata", rdata, 32'hFFFF8899);
    run(1'b0, F3_HU, 32'h42, 32'h0, 1'b0, lat);
    chk("lhu42_rdata", rdata, 32'h00008899);

    // Byte store through read-modify-write
    w0 = wr_cnt;
    run(1'b1, F3_B, 32'h43, 32'h11223344, 1'b0, lat);
    chk("sb43_lat", 32'(lat), 32'd3);
    chk("sb43_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sb43_word", mem['h10], 32'h4499AABB);

    // Misaligned requests
    w0 = wr_cnt;
    run(1'b1, F3_W, 32'h46, 32'hFFFFFFFF, 1'b0, lat);
    chk("sw46_lat", 32'(lat), 32'd1);
    chk("sw46_err", 32'(err), 32'd1);
    run(1'b0, F3_H, 32'h45, 32'h0, 1'b0, lat);
    chk("lh45_lat", 32'(lat), 32'd1);
    chk("lh45_err", 32'(err), 32'd1);
    chk("lh45_rdata_held", rdata, 32'h00008899);
    chk("misalign_writes", 32'(wr_cnt - w0), 32'd0);

    // Range boundary
    run(1'b0, F3_W, 32'h2000, 32'h0, 1'b0, lat);
    chk("lw2000_err", 32'(err), 32'd1);
    run(1'b0, F3_W, 32'h1FFC, 32'h0, 1'b0, lat);
    chk("lw1ffc_err", 32'(err), 32'd0);
    chk("lw1ffc_rdata", rdata, 32'hCAFEF00D);

    // Word/half stores and back-to-back loads
    run(1'b1, F3_W, 32'h50, 32'hDEADBEEF, 1'b0, lat);
    chk("sw50_lat", 32'(lat), 32'd2);
    run(1'b0, F3_W, 32'h50, 32'h0, 1'b1, lat);
    chk("lw50_rdata", rdata, 32'hDEADBEEF);
    run(1'b1, F3_H, 32'h52, 32'h00001234, 1'b0, lat);
    chk("sh52_word", mem['h14], 32'h1234BEEF);
    run(1'b0, F3_BU, 32'h53, 32'h0, 1'b1, lat);
    chk("lbu53_rdata", rdata, 32'h00000012);
    run(1'b0, F3_B, 32'h50, 32'h0, 1'b1, lat);
    chk("lb50_rdata", rdata, 32'hFFFFFFEF);

    // Illegal size codes and byte access past the end
    run(1'b0, 3'b011, 32'h40, 32'h0, 1'b0, lat);
    chk("ld011_err", 32'(err), 32'd1);
    run(1'b1, F3_HU, 32'h40, 32'h0, 1'b0, lat);
    chk("st101_err", 32'(err), 32'd1);
    run(1'b0, F3_B, 32'h2003, 32'h0, 1'b0, lat);
    chk("lb2003_err", 32'(err), 32'd1);
    chk("err_rdata_held", rdata, 32'hFFFFFFEF);

    // Reset during the write cycle of a halfword store
    chk_en = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; funct3 = F3_H; addr = 32'h62; wdata = 32'h00005555;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_wr_memwrite", 32'(mem_memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    chk("rstmid_mem_A", mem_A, 32'd0);
    chk("rstmid_mem_WD", mem_WD, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    chk("rstmid_word", mem['h18], 32'h13579BDF);
    @(negedge clk);
    #2 rst_n = 1'b1;
    act = 1'b0; rd_old = '0; rd_cur = '0;
    chk_en = 1'b1;
    run(1'b0, F3_W, 32'h60, 32'h0, 1'b0, lat);
    chk("lw60_after_rst", rdata, 32'h13579BDF);
    chk("lw60_lat", 32'(lat), 32'd2);

    // Memory image against the reference
    @(posedge clk); #1;
    for (int i = 'h10; i < 'h20; i++) chk("mem_image", mem[i], ref_mem[i]);
    chk("mem_image_top", mem['h7FF], ref_mem['h7FF]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
